// File: rtl/scan_ctrl_pkg.sv
// Shared opcodes, ASCII scan-bit codes and FSM encoding for scan_shift_ctrl.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SET  = 2'b00,
    OP_GET  = 2'b01,
    OP_EXEC = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_1 = 8'h31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_WAIT,
    ST_TX_REQ,
    ST_TX_WAIT,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } state_e;

  function automatic logic is_scan_char(input logic [7:0] b);
    return (b == ASCII_0) || (b == ASCII_1);
  endfunction

endpackage

// File: rtl/scan_shift_ctrl_part_clk_gen.sv
// Part clock pulse generator: one start gives CLK_DIV cycles low then CLK_DIV
// cycles high. A start on the final high cycle chains straight into the next pulse.
module part_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic part_clk,
  output logic lo_done,
  output logic pulse_done
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          hi_q, hi_d;
  logic          cnt_last;

  assign cnt_last   = (cnt_q == LAST);
  assign lo_done    = active_q & ~hi_q & cnt_last;
  assign pulse_done = active_q & hi_q & cnt_last;
  assign part_clk   = hi_q;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    hi_d     = hi_q;
    if (active_q) begin
      if (cnt_last) begin
        cnt_d = '0;
        if (!hi_q) begin
          hi_d = 1'b1;
        end else begin
          hi_d     = 1'b0;
          active_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (start && (!active_q || pulse_done)) begin
      active_d = 1'b1;
      hi_d     = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: rtl/scan_shift_ctrl.sv
// Scan shift controller: set/get scan state over UART bytes and run part clock
// cycles. Define SCAN_RECIRC_EN to recirculate scan-out into scan-in on get_state.
module scan_shift_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             busy,
  output logic             err,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             part_clk,
  output logic             part_se,
  output logic             part_tm,
  output logic             part_si,
  input  logic             part_so
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             err_q, err_d;
  logic             se_q, se_d;
  logic             tm_q, tm_d;
  logic             si_q, si_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pulse_start;
  logic             lo_done;
  logic             pulse_done;

  part_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rstn       (rstn),
    .start      (pulse_start),
    .part_clk   (part_clk),
    .lo_done    (lo_done),
    .pulse_done (pulse_done)
  );

  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign err       = err_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign part_se   = se_q;
  assign part_tm   = tm_q;
  assign part_si   = si_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    se_d        = se_q;
    tm_d        = tm_q;
    si_d        = si_q;
    tx_start_d  = tx_start_q;
    tx_data_d   = tx_data_q;
    pulse_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          len_d = cmd_len;
          cnt_d = '0;
          err_d = 1'b0;
          if ((cmd_len == '0) || (op_e'(cmd_op) == OP_NOP)) begin
            state_d = ST_DONE;
          end else begin
            case (op_e'(cmd_op))
              OP_SET: begin
                se_d    = 1'b1;
                tm_d    = 1'b1;
                state_d = ST_SET_WAIT;
              end
              OP_GET: begin
                se_d    = 1'b1;
                tm_d    = 1'b1;
                state_d = ST_TX_REQ;
              end
              default: begin
                se_d        = 1'b0;
                tm_d        = 1'b0;
                si_d        = 1'b0;
                pulse_start = 1'b1;
                state_d     = ST_CLK_LO;
              end
            endcase
          end
        end
      end

      ST_SET_WAIT: begin
        if (rx_valid) begin
          si_d = (rx_data == ASCII_1);
          if (!is_scan_char(rx_data)) err_d = 1'b1;
          pulse_start = 1'b1;
          state_d     = ST_CLK_LO;
        end
      end

      // First cycle raises the request and samples scan-out once; later cycles
      // hold the request until the UART acknowledges by dropping tx_ready.
      ST_TX_REQ: begin
        if (!tx_start_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = part_so ? ASCII_1 : ASCII_0;
`ifdef SCAN_RECIRC_EN
          si_d = part_so;
`else
          si_d = 1'b0;
`endif
        end else if (!tx_ready) begin
          tx_start_d = 1'b0;
          state_d    = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        if (tx_ready) begin
          pulse_start = 1'b1;
          state_d     = ST_CLK_LO;
        end
      end

      ST_CLK_LO: begin
        if (lo_done) state_d = ST_CLK_HI;
      end

      ST_CLK_HI: begin
        if (pulse_done) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = ST_DONE;
          end else begin
            case (op_q)
              OP_SET:  state_d = ST_SET_WAIT;
              OP_GET:  state_d = ST_TX_REQ;
              default: begin
                pulse_start = 1'b1;
                state_d     = ST_CLK_LO;
              end
            endcase
          end
        end
      end

      // Scan controls drop here, a full cycle after part_clk has fallen.
      ST_DONE: begin
        se_d    = 1'b0;
        tm_d    = 1'b0;
        si_d    = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_SET;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      se_q       <= 1'b0;
      tm_q       <= 1'b0;
      si_q       <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      se_q       <= se_d;
      tm_q       <= tm_d;
      si_q       <= si_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Directed bench for scan_shift_ctrl with a 6-bit scan chain model and a
// handshaking UART transmitter model.
module tb_scan_shift_ctrl;

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_GET  = 2'b01;
  localparam logic [1:0] OP_EXEC = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;
`ifdef SCAN_RECIRC_EN
  localparam logic [5:0] CHAIN_AFTER_GET = 6'b110010;
`else
  localparam logic [5:0] CHAIN_AFTER_GET = 6'b000000;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_len;
  logic        cmd_ready, busy, err;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        part_clk, part_se, part_tm, part_si, part_so;

  logic [5:0]  chain = '0;
  int          pulse_cnt = 0;
  int          sel_hi_cnt = 0;
  int          ctrl_glitch = 0;
  logic        si_log[$];
  time         rise_t[$];
  time         fall_t[$];
  logic [7:0]  tx_log[$];
  int          start_drop_early = 0;
  int          start_stuck = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  assign part_so = chain[5];

  scan_shift_ctrl #(
    .CLK_DIV (4),
    .LEN_W   (16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .err       (err),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .part_clk  (part_clk),
    .part_se   (part_se),
    .part_tm   (part_tm),
    .part_si   (part_si),
    .part_so   (part_so)
  );

  initial forever #5 clk = ~clk;

  // Part model: scan chain shifts on the rising part_clk while scan-enabled.
  always @(posedge part_clk) begin
    pulse_cnt <= pulse_cnt + 1;
    sel_hi_cnt <= sel_hi_cnt + ((part_se || part_tm) ? 1 : 0);
    si_log.push_back(part_si);
    rise_t.push_back($time);
    if (part_se) chain <= {chain[4:0], part_si};
  end

  always @(negedge part_clk) fall_t.push_back($time);

  always @(part_se or part_tm or part_si) begin
    if (part_clk === 1'b1 && rstn === 1'b1) ctrl_glitch <= ctrl_glitch + 1;
  end

  // UART transmitter model: acknowledges a request a few cycles late.
  initial begin : uart_model
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1 && tx_ready) begin
        tx_log.push_back(tx_data);
        repeat (2) begin
          @(posedge clk); #1;
          if (tx_start !== 1'b1) start_drop_early++;
        end
        tx_ready = 1'b0;
        @(posedge clk); #1;
        if (tx_start !== 1'b0) start_stuck++;
        repeat (4) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_si(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], si_log[base+i]};
    return v;
  endfunction

  function automatic logic [63:0] pack_tx(input int base, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], tx_log[base+i]};
    return v;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] len);
    @(negedge clk);
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns on the first negedge of clk after part_clk has fallen.
  task automatic wait_fall(input int max_cyc, input string tag);
    bit seen_hi = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (part_clk) seen_hi = 1'b1;
      else if (seen_hi) done = 1'b1;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic set_state(input string s);
    send_cmd(OP_SET, 16'(s.len()));
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) wait_fall(40, "set_pulse_wait");
      rx_data  = s[i];
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
    wait_fall(40, "set_last_pulse_wait");
  endtask

  initial begin : main
    int p0, s0, t0, r0, f0, h0;
    bit got;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
    rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_part_clk", part_clk, 1'b0);
    check("rst_part_se", part_se, 1'b0);
    check("rst_part_tm", part_tm, 1'b0);
    check("rst_part_si", part_si, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // set_state "110010"
    p0 = pulse_cnt; s0 = si_log.size(); h0 = sel_hi_cnt;
    set_state("110010");
    check("set6_ready_in_done", cmd_ready, 1'b0);
    check("set6_se_in_done", part_se, 1'b1);
    @(negedge clk);
    check("set6_ready_after_done", cmd_ready, 1'b1);
    check("set6_se_dropped", part_se, 1'b0);
    check("set6_tm_dropped", part_tm, 1'b0);
    check("set6_si_dropped", part_si, 1'b0);
    check("set6_pulses", pulse_cnt - p0, 6);
    check("set6_si_seq", pack_si(s0, 6), 64'b110010);
    check("set6_se_tm_at_rise", sel_hi_cnt - h0, 6);
    check("set6_err", err, 1'b0);
    check("set6_chain", chain, 6'b110010);

    // get_state 6 bits
    p0 = pulse_cnt; t0 = tx_log.size();
    send_cmd(OP_GET, 16'd6);
    wait_idle(1000, "get6_done_wait");
    check("get6_tx_count", tx_log.size() - t0, 6);
    if (tx_log.size() - t0 == 6) check("get6_tx_bytes", pack_tx(t0, 6), 64'h3131_3030_3130);
    check("get6_pulses", pulse_cnt - p0, 6);
    check("get6_chain", chain, CHAIN_AFTER_GET);
    check("get6_start_dropped_early", start_drop_early, 0);
    check("get6_start_not_released", start_stuck, 0);
    check("get6_tx_start_idle", tx_start, 1'b0);

    // set_state "1x": bad byte flags err, drives 0
    p0 = pulse_cnt; s0 = si_log.size();
    set_state("1x");
    @(negedge clk);
    check("set2_pulses", pulse_cnt - p0, 2);
    check("set2_si_seq", pack_si(s0, 2), 64'b10);
    check("set2_err", err, 1'b1);

    // execute 4 with busy-time cmd_valid and rx_valid that must be ignored
    p0 = pulse_cnt; r0 = rise_t.size(); f0 = fall_t.size(); h0 = sel_hi_cnt;
    s0 = si_log.size();
    send_cmd(OP_EXEC, 16'd4);
    check("exec_err_cleared", err, 1'b0);
    check("exec_busy", busy, 1'b1);
    rx_data = 8'h78; rx_valid = 1'b1;
    cmd_op = OP_SET; cmd_len = 16'd1; cmd_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle(200, "exec4_done_wait");
    check("exec4_pulses", pulse_cnt - p0, 4);
    check("exec4_se_tm_low", sel_hi_cnt - h0, 0);
    check("exec4_si_low", pack_si(s0, 4), 64'b0);
    check("exec4_err", err, 1'b0);
    if (rise_t.size() - r0 >= 2 && fall_t.size() - f0 >= 1) begin
      check("exec4_period", rise_t[r0+1] - rise_t[r0], 64'd80);
      check("exec4_high_width", fall_t[f0] - rise_t[r0], 64'd40);
    end else begin
      check("exec4_edges_seen", rise_t.size() - r0, 4);
    end
    repeat (20) @(negedge clk);
    check("exec4_stays_idle", cmd_ready, 1'b1);
    check("exec4_no_extra_pulse", pulse_cnt - p0, 4);
    check("ctrl_change_while_clk_high", ctrl_glitch, 0);

    // zero-length execute and reserved op
    p0 = pulse_cnt;
    send_cmd(OP_EXEC, 16'd0);
    check("len0_busy", busy, 1'b1);
    @(negedge clk);
    check("len0_ready", cmd_ready, 1'b1);
    send_cmd(OP_NOP, 16'd3);
    check("nop_busy", busy, 1'b1);
    @(negedge clk);
    check("nop_ready", cmd_ready, 1'b1);
    check("len0_nop_no_pulse", pulse_cnt - p0, 0);

    // reset while a get_state request is outstanding
    send_cmd(OP_GET, 16'd1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = tx_start;
    end
    check("midtx_start_seen", got, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("midtx_rst_tx_start", tx_start, 1'b0);
    check("midtx_rst_tx_data", tx_data, 8'h00);
    check("midtx_rst_se", part_se, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    // reset in the middle of the high phase
    p0 = pulse_cnt;
    send_cmd(OP_EXEC, 16'd3);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = part_clk;
    end
    check("midhi_clk_high_seen", got, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("midhi_rst_part_clk", part_clk, 1'b0);
    check("midhi_rst_cmd_ready", cmd_ready, 1'b1);
    check("midhi_rst_busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("midhi_no_resume", pulse_cnt - p0, 1);
    check("midhi_idle", cmd_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
